// File: rtl/frame_sequencer_pkg.sv
// Shared types and defaults for the Game-of-Life frame scheduler.
package frame_seq_pkg;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        LIFE_ISSUE,
        LIFE_WAIT,
        SWAP,
        TX_ISSUE,
        TX_WAIT,
        LATCH
    } state_t;

    localparam int CLK_HZ            = 12000000;
    localparam int UPDATE_CYCLES_DEF = CLK_HZ / 2;               // 0.5 s
    localparam int RESET_CYCLES_DEF  = (CLK_HZ / 1000000) * 300; // 300 us

    // Bits needed for a counter running 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Start/done handshake between the sequencer, the life engine and the WS2812 controller.
interface frame_sequencer_if;
    logic life_start;
    logic life_done;
    logic tx_start;
    logic tx_done;

    modport master (output life_start, output tx_start, input life_done, input tx_done);
    modport slave  (input life_start, input tx_start, output life_done, output tx_done);
endinterface

// File: rtl/frame_sequencer_period_timer.sv
// Free-running auto-update period counter; advances only while run_en is high.
module period_timer
    import frame_seq_pkg::*;
#(
    parameter int UPDATE_CYCLES = UPDATE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run_en,
    output logic tick
);
    localparam int           W    = cnt_w(UPDATE_CYCLES);
    localparam logic [W-1:0] LAST = W'(UPDATE_CYCLES - 1);

    logic [W-1:0] period_cnt;

    // Pausing freezes the count so a resumed run keeps its phase.
    always_ff @(posedge clk) begin
        if (rst)
            period_cnt <= '0;
        else if (run_en)
            period_cnt <= (period_cnt == LAST) ? '0 : period_cnt + W'(1);
    end

    assign tick = run_en && (period_cnt == LAST);
endmodule

// File: rtl/frame_sequencer.sv
// Schedules life-engine generations, front/back buffer swaps and WS2812 frame transmits.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int UPDATE_CYCLES = UPDATE_CYCLES_DEF,
    parameter int RESET_CYCLES  = RESET_CYCLES_DEF,
    parameter int GEN_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              update_req,
    frame_sequencer_if.master hs,
    output logic              buf_sel,
    output logic              latch_active,
    output logic              busy,
    output logic [GEN_W-1:0]  gen_count,
    output logic [7:0]        overrun_cnt
);
    localparam int            LW         = cnt_w(RESET_CYCLES);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);

    state_t        state, state_nxt;
    logic          tick;
    logic          req;
    logic          pending;
    logic [LW-1:0] latch_cnt;

    period_timer #(.UPDATE_CYCLES(UPDATE_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run_en (run_en),
        .tick   (tick)
    );

    assign req = tick || update_req;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:       state_nxt = TX_ISSUE;   // show the seed frame before evolving
            IDLE:       if (pending || req) state_nxt = LIFE_ISSUE;
            LIFE_ISSUE: state_nxt = LIFE_WAIT;
            LIFE_WAIT:  if (hs.life_done) state_nxt = SWAP;
            SWAP:       state_nxt = TX_ISSUE;
            TX_ISSUE:   state_nxt = TX_WAIT;
            TX_WAIT:    if (hs.tx_done) state_nxt = LATCH;
            LATCH:      if (latch_cnt == LATCH_LAST) state_nxt = IDLE;
            default:    state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pending     <= 1'b0;
            latch_cnt   <= '0;
            buf_sel     <= 1'b0;
            gen_count   <= '0;
            overrun_cnt <= '0;
        end else begin
            state <= state_nxt;

            // Requests arriving while busy collapse into a single deferred update.
            if (state == IDLE)
                pending <= 1'b0;
            else if (req)
                pending <= 1'b1;

            if (state != IDLE && tick && pending && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            latch_cnt <= (state == LATCH && state_nxt == LATCH) ? latch_cnt + LW'(1) : '0;

            if (state == SWAP) begin
                buf_sel   <= ~buf_sel;
                gen_count <= gen_count + GEN_W'(1);
            end
        end
    end

    assign hs.life_start = (state == LIFE_ISSUE);
    assign hs.tx_start   = (state == TX_ISSUE);
    assign latch_active  = (state == LATCH);
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_frame_sequencer;
    localparam int UPD  = 20;
    localparam int RSTC = 5;
    localparam int GW   = 16;

    localparam int M_BOOT = 0, M_IDLE = 1, M_LIFE_GO = 2, M_LIFE_RUN = 3,
                   M_FLIP = 4, M_TX_GO = 5, M_TX_RUN = 6, M_GAP = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run_en = 1'b0;
    logic          update_req = 1'b0;
    logic          buf_sel, latch_active, busy;
    logic [GW-1:0] gen_count;
    logic [7:0]    overrun_cnt;

    frame_sequencer_if hs();

    frame_sequencer #(.UPDATE_CYCLES(UPD), .RESET_CYCLES(RSTC), .GEN_W(GW)) dut (
        .clk          (clk),
        .rst          (rst),
        .run_en       (run_en),
        .update_req   (update_req),
        .hs           (hs),
        .buf_sel      (buf_sel),
        .latch_active (latch_active),
        .busy         (busy),
        .gen_count    (gen_count),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_gen = 0;
    logic exp_buf = 1'b0;
    int exp_ovr = 0;

    // Reference model: phase of the frame cycle, elapsed run time, outstanding request.
    int          m_ph = M_BOOT;
    int          m_run_cycles = 0;
    int          m_gap_left = 0;
    bit          m_want = 0;
    bit          m_buf = 0;
    logic [15:0] m_gen = '0;
    int          m_ovr = 0;

    task automatic model_step();
        bit tk, rq;
        if (rst) begin
            m_ph = M_BOOT; m_run_cycles = 0; m_gap_left = 0; m_want = 0;
            m_buf = 0; m_gen = '0; m_ovr = 0;
        end else begin
            tk = run_en && ((m_run_cycles % UPD) == UPD - 1);
            if (run_en) m_run_cycles++;
            rq = tk || update_req;
            if (m_ph != M_IDLE) begin
                if (tk && m_want && m_ovr < 255) m_ovr++;
                if (rq) m_want = 1;
            end
            case (m_ph)
                M_BOOT:     m_ph = M_TX_GO;
                M_IDLE:     if (m_want || rq) begin m_ph = M_LIFE_GO; m_want = 0; end
                M_LIFE_GO:  m_ph = M_LIFE_RUN;
                M_LIFE_RUN: if (hs.life_done) m_ph = M_FLIP;
                M_FLIP:     begin m_buf = !m_buf; m_gen = m_gen + 16'd1; m_ph = M_TX_GO; end
                M_TX_GO:    m_ph = M_TX_RUN;
                M_TX_RUN:   if (hs.tx_done) begin m_ph = M_GAP; m_gap_left = RSTC; end
                default: begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_ph = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // From a TX_ISSUE cycle: tx_done d cycles later, then ride out the latch gap.
    task automatic finish_tx(input int d);
        repeat (d) step();
        hs.tx_done = 1'b1;
        step();
        hs.tx_done = 1'b0;
        repeat (RSTC) step();
    endtask

    // From a LIFE_ISSUE cycle all the way back to IDLE.
    task automatic complete_update(input int ld, input int td);
        repeat (ld) step();
        hs.life_done = 1'b1;
        step();
        hs.life_done = 1'b0;
        step();
        finish_tx(td);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_checks++; if (buf_sel !== 1'b0) begin n_errors++; $display("FAIL reset_buf_sel: got %b want 0", buf_sel); end
        n_checks++; if (gen_count !== '0) begin n_errors++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
        n_checks++; if (overrun_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_ovr: got %0d want 0", overrun_cnt); end
        n_checks++;
        if ({hs.life_start, hs.tx_start, latch_active} !== 3'b000) begin
            n_errors++; $display("FAIL reset_pulses: got %b want 000", {hs.life_start, hs.tx_start, latch_active});
        end
    endtask

    task automatic test_boot();
        int lat = 0;
        rst = 1'b0;
        n_checks++; if (hs.tx_start !== 1'b0) begin n_errors++; $display("FAIL boot_tx_early: got %b want 0", hs.tx_start); end
        step();
        n_checks++; if (hs.tx_start !== 1'b1) begin n_errors++; $display("FAIL boot_tx_start: got %b want 1", hs.tx_start); end
        repeat (9) step();
        hs.tx_done = 1'b1;
        step();
        hs.tx_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (latch_active === 1'b1) lat++;
            step();
        end
        n_checks++; if (lat != RSTC) begin n_errors++; $display("FAIL boot_latch_len: got %0d want %0d", lat, RSTC); end
        n_checks++;
        if ({busy, buf_sel} !== 2'b00 || gen_count !== '0) begin
            n_errors++; $display("FAIL boot_idle: got busy=%b buf=%b gen=%0d want 0 0 0", busy, buf_sel, gen_count);
        end
    endtask

    task automatic test_auto_update();
        int k = 0;
        int d = $urandom_range(3, 9);
        run_en = 1'b1;
        while (hs.life_start !== 1'b1 && k < 40) begin step(); k++; end
        run_en = 1'b0;
        n_checks++; if (k != UPD) begin n_errors++; $display("FAIL auto_tick_latency: got %0d want %0d", k, UPD); end
        step();
        n_checks++; if (hs.life_start !== 1'b0) begin n_errors++; $display("FAIL auto_life_pulse: got %b want 0", hs.life_start); end
        repeat (d - 1) step();
        hs.life_done = 1'b1;
        step();
        hs.life_done = 1'b0;
        n_checks++; if (hs.tx_start !== 1'b0) begin n_errors++; $display("FAIL auto_tx_early: got %b want 0", hs.tx_start); end
        step();
        exp_buf = 1'b1; exp_gen = 1;
        n_checks++; if (hs.tx_start !== 1'b1) begin n_errors++; $display("FAIL auto_tx_start: got %b want 1", hs.tx_start); end
        n_checks++;
        if (buf_sel !== exp_buf || gen_count !== GW'(exp_gen)) begin
            n_errors++; $display("FAIL auto_swap: got buf=%b gen=%0d want %b %0d", buf_sel, gen_count, exp_buf, exp_gen);
        end
        finish_tx($urandom_range(1, 12));
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL auto_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_overrun();
        int k = 0;
        int extra = 0;
        run_en = 1'b1;
        while (hs.life_start !== 1'b1 && k < 40) begin step(); k++; end
        n_checks++; if (k >= 40) begin n_errors++; $display("FAIL ovr_start_timeout: got %0d cycles want <40", k); end
        for (int j = 1; j <= 50; j++) begin
            step();
            if (hs.life_start === 1'b1) extra++;
            if (j == 30) begin
                n_checks++; if (overrun_cnt !== 8'(exp_ovr)) begin n_errors++; $display("FAIL ovr_first_tick: got %0d want %0d", overrun_cnt, exp_ovr); end
            end
            if (j == 45) begin
                exp_ovr = 1;
                n_checks++; if (overrun_cnt !== 8'(exp_ovr)) begin n_errors++; $display("FAIL ovr_second_tick: got %0d want %0d", overrun_cnt, exp_ovr); end
            end
        end
        n_checks++; if (extra != 0) begin n_errors++; $display("FAIL ovr_no_restart: got %0d want 0", extra); end
        hs.life_done = 1'b1;
        run_en = 1'b0;
        step();
        hs.life_done = 1'b0;
        step();
        exp_buf = 1'b0; exp_gen = 2;
        n_checks++; if (hs.tx_start !== 1'b1 || buf_sel !== exp_buf) begin n_errors++; $display("FAIL ovr_tx: got tx=%b buf=%b want 1 %b", hs.tx_start, buf_sel, exp_buf); end
        finish_tx($urandom_range(1, 12));
        n_checks++; if ({busy, hs.life_start} !== 2'b00) begin n_errors++; $display("FAIL ovr_idle_entry: got %b want 00", {busy, hs.life_start}); end
        step();
        n_checks++; if (hs.life_start !== 1'b1) begin n_errors++; $display("FAIL ovr_pending_start: got %b want 1", hs.life_start); end
        complete_update($urandom_range(1, 8), $urandom_range(1, 12));
        exp_buf = 1'b1; exp_gen = 3;
        n_checks++;
        if (gen_count !== GW'(exp_gen) || buf_sel !== exp_buf || overrun_cnt !== 8'(exp_ovr)) begin
            n_errors++; $display("FAIL ovr_final: got gen=%0d buf=%b ovr=%0d want %0d %b %0d",
                                 gen_count, buf_sel, overrun_cnt, exp_gen, exp_buf, exp_ovr);
        end
    endtask

    task automatic test_pause_step();
        int starts = 0;
        run_en = 1'b0;
        repeat (100) begin step(); if (hs.life_start === 1'b1) starts++; end
        n_checks++; if (starts != 0) begin n_errors++; $display("FAIL pause_no_update: got %0d want 0", starts); end
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        n_checks++; if (hs.life_start !== 1'b1) begin n_errors++; $display("FAIL step_start: got %b want 1", hs.life_start); end
        repeat ($urandom_range(1, 8)) step();
        hs.life_done = 1'b1;
        step();
        hs.life_done = 1'b0;
        step();
        step();
        update_req = 1'b1; step(); update_req = 1'b0;
        step(); step();
        update_req = 1'b1; step(); update_req = 1'b0;
        hs.tx_done = 1'b1;
        step();
        hs.tx_done = 1'b0;
        repeat (RSTC) step();
        step();
        n_checks++; if (hs.life_start !== 1'b1) begin n_errors++; $display("FAIL step_followup: got %b want 1", hs.life_start); end
        complete_update($urandom_range(1, 8), $urandom_range(1, 12));
        starts = 0;
        repeat (30) begin step(); if (hs.life_start === 1'b1) starts++; end
        exp_gen = 5; exp_buf = 1'b1;
        n_checks++; if (starts != 0) begin n_errors++; $display("FAIL step_collapse: got %0d extra want 0", starts); end
        n_checks++;
        if (overrun_cnt !== 8'(exp_ovr) || gen_count !== GW'(exp_gen) || buf_sel !== exp_buf) begin
            n_errors++; $display("FAIL step_counts: got ovr=%0d gen=%0d buf=%b want %0d %0d %b",
                                 overrun_cnt, gen_count, buf_sel, exp_ovr, exp_gen, exp_buf);
        end
    endtask

    task automatic test_stray();
        int starts = 0;
        update_req = 1'b1; step(); update_req = 1'b0;
        step();
        hs.tx_done = 1'b1; step(); hs.tx_done = 1'b0;
        step();
        n_checks++;
        if ({busy, hs.tx_start, latch_active} !== 3'b100 || buf_sel !== exp_buf) begin
            n_errors++; $display("FAIL stray_tx_done: got busy/tx/latch=%b buf=%b want 100 %b",
                                 {busy, hs.tx_start, latch_active}, buf_sel, exp_buf);
        end
        hs.life_done = 1'b1; step(); hs.life_done = 1'b0;
        step();
        exp_gen = 6; exp_buf = 1'b0;
        n_checks++; if (hs.tx_start !== 1'b1 || gen_count !== GW'(exp_gen)) begin n_errors++; $display("FAIL stray_swap: got tx=%b gen=%0d want 1 %0d", hs.tx_start, gen_count, exp_gen); end
        step(); step();
        hs.life_done = 1'b1; hs.tx_done = 1'b1;
        step();
        hs.life_done = 1'b0; hs.tx_done = 1'b0;
        n_checks++;
        if (latch_active !== 1'b1 || gen_count !== GW'(exp_gen) || buf_sel !== exp_buf) begin
            n_errors++; $display("FAIL stray_both_done: got latch=%b gen=%0d buf=%b want 1 %0d %b",
                                 latch_active, gen_count, buf_sel, exp_gen, exp_buf);
        end
        update_req = 1'b1; step(); update_req = 1'b0;
        rst = 1'b1;
        step();
        exp_gen = 0; exp_buf = 1'b0; exp_ovr = 0;
        n_checks++;
        if ({busy, latch_active, buf_sel} !== 3'b100 || gen_count !== '0 || overrun_cnt !== 8'd0) begin
            n_errors++; $display("FAIL mid_latch_reset: got busy/latch/buf=%b gen=%0d ovr=%0d want 100 0 0",
                                 {busy, latch_active, buf_sel}, gen_count, overrun_cnt);
        end
        rst = 1'b0;
        step();
        n_checks++; if (hs.tx_start !== 1'b1) begin n_errors++; $display("FAIL reboot_tx: got %b want 1", hs.tx_start); end
        finish_tx(3);
        repeat (30) begin step(); if (hs.life_start === 1'b1) starts++; end
        n_checks++; if (starts != 0) begin n_errors++; $display("FAIL reset_clears_pending: got %0d want 0", starts); end
    endtask

    task automatic test_random(input int ncyc);
        int life_cd = -1;
        int tx_cd = -1;
        run_en = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 99) == 0) run_en = !run_en;
            update_req   = ($urandom_range(0, 39) == 0);
            hs.life_done = (life_cd == 0) || ($urandom_range(0, 59) == 0);
            hs.tx_done   = (tx_cd == 0) || ($urandom_range(0, 59) == 0);
            if (life_cd >= 0) life_cd--;
            if (tx_cd >= 0) tx_cd--;
            if (rst) begin life_cd = -1; tx_cd = -1; end
            step();
            n_checks++; if (hs.life_start !== (m_ph == M_LIFE_GO)) begin n_errors++; $display("FAIL rnd_life_start c=%0d: got %b want %b", c, hs.life_start, m_ph == M_LIFE_GO); end
            n_checks++; if (hs.tx_start !== (m_ph == M_TX_GO)) begin n_errors++; $display("FAIL rnd_tx_start c=%0d: got %b want %b", c, hs.tx_start, m_ph == M_TX_GO); end
            n_checks++; if (latch_active !== (m_ph == M_GAP)) begin n_errors++; $display("FAIL rnd_latch c=%0d: got %b want %b", c, latch_active, m_ph == M_GAP); end
            n_checks++; if (busy !== (m_ph != M_IDLE)) begin n_errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_ph != M_IDLE); end
            n_checks++; if (buf_sel !== m_buf) begin n_errors++; $display("FAIL rnd_buf_sel c=%0d: got %b want %b", c, buf_sel, m_buf); end
            n_checks++; if (gen_count !== m_gen) begin n_errors++; $display("FAIL rnd_gen c=%0d: got %0d want %0d", c, gen_count, m_gen); end
            n_checks++; if (overrun_cnt !== 8'(m_ovr)) begin n_errors++; $display("FAIL rnd_ovr c=%0d: got %0d want %0d", c, overrun_cnt, m_ovr); end
            if (hs.life_start === 1'b1) life_cd = $urandom_range(0, 9);
            if (hs.tx_start === 1'b1) tx_cd = $urandom_range(0, 14);
        end
        rst = 1'b0; update_req = 1'b0; hs.life_done = 1'b0; hs.tx_done = 1'b0;
    endtask

    initial begin
        hs.life_done = 1'b0;
        hs.tx_done   = 1'b0;
        test_reset();
        test_boot();
        test_auto_update();
        test_overrun();
        test_pause_step();
        test_stray();
        test_random(4000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
